rom_dl_ctrl: RTL



---
 rtl/rom_dl_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rom_dl_ctrl.sv
// ROM download controller: filters the ioctl stream into the core's ROM write port,
// captures the variant byte, validates the image and sequences the core reset.
module rom_dl_ctrl #(
  parameter logic [15:0] ROM_SIZE    = 16'hC000,
  parameter int          HOLD_CYCLES = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [7:0]  mod,
  output logic        mod_orig,
  output logic        mod_plus,
  output logic        mod_club,
  output logic        mod_crush,
  output logic        mod_bird,
  output logic        core_reset,
  output logic        rom_valid,
  output logic        dl_error,
  output logic [15:0] checksum,
  output logic [16:0] byte_count
);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        dl_prev_reg;
  logic [7:0]  sess_idx_reg;
  logic [15:0] hold_cnt_reg, hold_cnt_next;
  logic        ovf_reg, ovf_next;
  logic [16:0] byte_count_reg, byte_count_next;
  logic [15:0] checksum_reg, checksum_next;
  logic        rom_valid_reg, rom_valid_next;
  logic        dl_error_reg, dl_error_next;
  logic [15:0] dn_addr_reg;
  logic [7:0]  dn_data_reg;
  logic        dn_wr_reg;
  logic [7:0]  mod_reg;
  logic [4:0]  mod_dec_reg;
  logic        core_reset_reg;

  logic dl_start, dl_end, in_load, rom_hit, rom_miss, mod_hit, image_good;

  assign dl_start = ioctl_download & ~dl_prev_reg;
  assign dl_end   = ~ioctl_download & dl_prev_reg;
  assign in_load  = (state_reg == LOAD) && ioctl_wr;
  assign rom_hit  = in_load && (sess_idx_reg == 8'd0) && (ioctl_addr < 25'(ROM_SIZE));
  assign rom_miss = in_load && (sess_idx_reg == 8'd0) && !(ioctl_addr < 25'(ROM_SIZE));
  assign mod_hit  = in_load && (sess_idx_reg == 8'd1);

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    ovf_next        = ovf_reg;
    byte_count_next = byte_count_reg;
    checksum_next   = checksum_reg;
    rom_valid_next  = rom_valid_reg;
    dl_error_next   = dl_error_reg;

    // The strobe coinciding with the falling edge must count before the image check.
    if (rom_hit) begin
      if (byte_count_reg != '1)
        byte_count_next = byte_count_reg + 17'd1;
      checksum_next = checksum_reg + {8'd0, ioctl_dout};
    end
    if (rom_miss)
      ovf_next = 1'b1;
    image_good = (byte_count_next == {1'b0, ROM_SIZE}) && !ovf_next;

    if (state_reg == HOLD && hold_cnt_reg != 16'd0)
      hold_cnt_next = hold_cnt_reg - 16'd1;

    if (dl_start) begin
      state_next = LOAD;
      if (ioctl_index == 8'd0) begin
        byte_count_next = '0;
        checksum_next   = '0;
        ovf_next        = 1'b0;
      end
    end else begin
      unique case (state_reg)
        LOAD: begin
          if (dl_end) begin
            if (sess_idx_reg == 8'd0) begin
              rom_valid_next = image_good;
              dl_error_next  = !image_good;
              state_next     = image_good ? HOLD : ERR;
            end else if (rom_valid_reg) begin
              state_next = HOLD;
            end else begin
              state_next = dl_error_reg ? ERR : IDLE;
            end
          end
        end
        HOLD: begin
          if (hold_cnt_reg == 16'd0)
            state_next = RUN;
        end
        default: ;
      endcase
    end

    if (state_next == HOLD && state_reg != HOLD)
      hold_cnt_next = HOLD_INIT;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      // Loading the live level means a session already open at release is never seen.
      dl_prev_reg    <= ioctl_download;
      sess_idx_reg   <= 8'd0;
      hold_cnt_reg   <= 16'd0;
      ovf_reg        <= 1'b0;
      byte_count_reg <= '0;
      checksum_reg   <= '0;
      rom_valid_reg  <= 1'b0;
      dl_error_reg   <= 1'b0;
      dn_addr_reg    <= '0;
      dn_data_reg    <= '0;
      dn_wr_reg      <= 1'b0;
      mod_reg        <= '0;
      mod_dec_reg    <= 5'b00001;
      core_reset_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      dl_prev_reg    <= ioctl_download;
      if (dl_start)
        sess_idx_reg <= ioctl_index;
      hold_cnt_reg   <= hold_cnt_next;
      ovf_reg        <= ovf_next;
      byte_count_reg <= byte_count_next;
      checksum_reg   <= checksum_next;
      rom_valid_reg  <= rom_valid_next;
      dl_error_reg   <= dl_error_next;
      dn_wr_reg      <= rom_hit;
      if (rom_hit) begin
        dn_addr_reg <= ioctl_addr[15:0];
        dn_data_reg <= ioctl_dout;
      end
      if (mod_hit)
        mod_reg <= ioctl_dout;
      for (int k = 0; k < 5; k++)
        mod_dec_reg[k] <= (mod_reg == 8'(k));
      core_reset_reg <= (state_next != RUN);
    end
  end

  assign dn_addr    = dn_addr_reg;
  assign dn_data    = dn_data_reg;
  assign dn_wr      = dn_wr_reg;
  assign mod        = mod_reg;
  assign mod_orig   = mod_dec_reg[0];
  assign mod_plus   = mod_dec_reg[1];
  assign mod_club   = mod_dec_reg[2];
  assign mod_crush  = mod_dec_reg[3];
  assign mod_bird   = mod_dec_reg[4];
  assign core_reset = core_reset_reg;
  assign rom_valid  = rom_valid_reg;
  assign dl_error   = dl_error_reg;
  assign checksum   = checksum_reg;
  assign byte_count = byte_count_reg;

endmodule
